nn_inference_sequencer: RTL and testbench

- Central controller for the digit-classifier datapath; sits between the UART byte receiver, the image RAM and the shared MAC/activation datapath.
- Captures a 784-byte image into image RAM, then waits for a read request.
- Sequences both fully-connected layers neuron by neuron, performs argmax on the output-layer scores, and reports the classified digit.

---
 rtl/nn_inference_sequencer.sv | 179 +++++++++++++++++
 tb/tb_nn_inference_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inference_sequencer.sv
`timescale 1ns/1ps
// Digit-classifier controller: captures a 784-byte image, then runs both FC layers neuron by neuron and argmaxes layer 1.
// Latency: N_HID*(N_IN+MAC_LAT+3) + N_OUT*(N_HID+MAC_LAT+3) cycles from request; each neuron stalls in DRAIN until acc_valid.
// Optional NN_RELOAD_EN: dropping read_request in DONE re-arms image capture without a reset.
module nn_inference_sequencer #(
    parameter int N_IN     = 784,
    parameter int N_HID    = 32,
    parameter int N_OUT    = 10,
    parameter int ACC_W    = 24,
    parameter int MAC_LAT  = 3,
    parameter int W_ADDR_W = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_byte_valid,
    input  logic                    read_request,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic                    acc_valid,
    output logic                    img_we,
    output logic [9:0]              img_waddr,
    output logic                    image_written,
    output logic                    read_enable,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [9:0]              in_addr,
    output logic                    layer_sel,
    output logic [W_ADDR_W-1:0]     w_addr,
    output logic                    act_we,
    output logic [5:0]              neuron_idx,
    output logic                    NN_done,
    output logic [3:0]              digit_out
);

    if (N_OUT > 16 || N_IN > 1024 || MAC_LAT < 1 ||
        W_ADDR_W < $clog2(N_IN*N_HID + N_HID*N_OUT)) begin : g_bad_cfg
        $error("nn_inference_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_LOAD, S_WAIT_REQ, S_CLR, S_MAC, S_DRAIN, S_WB, S_NEXT, S_DONE
    } state_t;

    localparam logic [9:0] IMG_LAST = 10'(N_IN - 1);
    localparam logic [9:0] L1_FIN_LAST = 10'(N_HID - 1);
    localparam logic [5:0] L0_N_LAST = 6'(N_HID - 1);
    localparam logic [5:0] L1_N_LAST = 6'(N_OUT - 1);

    state_t                    r_state;
    logic [9:0]                r_cnt;
    logic [W_ADDR_W-1:0]       r_w_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_best;
    logic [3:0]                r_digit;

    logic [9:0] w_fin_last;
    logic [5:0] w_n_last;

    assign w_fin_last = layer_sel ? L1_FIN_LAST : IMG_LAST;
    assign w_n_last   = layer_sel ? L1_N_LAST : L0_N_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_w_cnt       <= '0;
            r_acc         <= '0;
            r_best        <= '0;
            r_digit       <= '0;
            img_we        <= 1'b0;
            img_waddr     <= '0;
            image_written <= 1'b0;
            read_enable   <= 1'b0;
            mac_clr       <= 1'b0;
            mac_en        <= 1'b0;
            in_addr       <= '0;
            layer_sel     <= 1'b0;
            w_addr        <= '0;
            act_we        <= 1'b0;
            neuron_idx    <= '0;
            NN_done       <= 1'b0;
            digit_out     <= '0;
        end else begin
            img_we  <= 1'b0;
            mac_clr <= 1'b0;
            act_we  <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (rx_byte_valid) begin
                        img_we    <= 1'b1;
                        img_waddr <= r_cnt;
                        r_cnt     <= r_cnt + 10'd1;
                        if (r_cnt == IMG_LAST) begin
                            image_written <= 1'b1;
                            r_state       <= S_WAIT_REQ;
                        end
                    end
                end
                S_WAIT_REQ: begin
                    if (read_request) begin
                        mac_clr     <= 1'b1;
                        read_enable <= 1'b1;
                        layer_sel   <= 1'b0;
                        neuron_idx  <= '0;
                        in_addr     <= '0;
                        w_addr      <= '0;
                        r_w_cnt     <= '0;
                        r_state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    // Weight address is continuous across neurons and layers
                    mac_en  <= 1'b1;
                    in_addr <= '0;
                    w_addr  <= r_w_cnt;
                    r_w_cnt <= r_w_cnt + W_ADDR_W'(1);
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (in_addr == w_fin_last) begin
                        mac_en  <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        in_addr <= in_addr + 10'd1;
                        w_addr  <= r_w_cnt;
                        r_w_cnt <= r_w_cnt + W_ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (acc_valid) begin
                        r_acc   <= acc_in;
                        act_we  <= !layer_sel;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    // Strict signed compare: ties keep the lower index
                    if (layer_sel && (neuron_idx == 6'd0 || r_acc > r_best)) begin
                        r_best  <= r_acc;
                        r_digit <= neuron_idx[3:0];
                    end
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (neuron_idx == w_n_last) begin
                        if (!layer_sel) begin
                            layer_sel  <= 1'b1;
                            neuron_idx <= '0;
                            in_addr    <= '0;
                            mac_clr    <= 1'b1;
                            r_state    <= S_CLR;
                        end else begin
                            NN_done     <= 1'b1;
                            digit_out   <= r_digit;
                            read_enable <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        neuron_idx <= neuron_idx + 6'd1;
                        in_addr    <= '0;
                        mac_clr    <= 1'b1;
                        r_state    <= S_CLR;
                    end
                end
                S_DONE: begin
`ifdef NN_RELOAD_EN
                    if (!read_request) begin
                        NN_done       <= 1'b0;
                        image_written <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_LOAD;
                    end
`endif
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
`timescale 1ns/1ps
// Directed bench: full-size sequencer run plus a reduced-size instance for argmax cases.
// Honours NN_RELOAD_EN for the post-DONE behaviour.
module tb_nn_inference_sequencer;

    localparam int N_IN = 784, N_HID = 32, N_OUT = 10, MAC_LAT = 3;
    localparam int S_IN = 4, S_HID = 2, S_OUT = 3;
    localparam int LAT_BIG   = N_HID*(N_IN+MAC_LAT+3) + N_OUT*(N_HID+MAC_LAT+3);
    localparam int LAT_SMALL = S_HID*(S_IN+MAC_LAT+3) + S_OUT*(S_HID+MAC_LAT+3);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // full-size instance
    logic               rst_n = 1'b0, rx_v = 1'b0, rreq = 1'b0, accv = 1'b0;
    logic signed [23:0] acc = '0;
    logic               b_img_we, b_image_written, b_read_enable, b_mac_clr, b_mac_en;
    logic               b_layer_sel, b_act_we, b_NN_done;
    logic [9:0]         b_img_waddr, b_in_addr;
    logic [14:0]        b_w_addr;
    logic [5:0]         b_neuron_idx;
    logic [3:0]         b_digit_out;
    logic [52:0]        b_outs;
    assign b_outs = {b_img_we, b_img_waddr, b_image_written, b_read_enable, b_mac_clr, b_mac_en,
                     b_in_addr, b_layer_sel, b_w_addr, b_act_we, b_neuron_idx, b_NN_done, b_digit_out};

    nn_inference_sequencer dut (
        .clk(clk), .reset(rst_n), .rx_byte_valid(rx_v), .read_request(rreq),
        .acc_in(acc), .acc_valid(accv),
        .img_we(b_img_we), .img_waddr(b_img_waddr), .image_written(b_image_written),
        .read_enable(b_read_enable), .mac_clr(b_mac_clr), .mac_en(b_mac_en),
        .in_addr(b_in_addr), .layer_sel(b_layer_sel), .w_addr(b_w_addr), .act_we(b_act_we),
        .neuron_idx(b_neuron_idx), .NN_done(b_NN_done), .digit_out(b_digit_out)
    );

    // reduced instance
    logic               s_rst_n = 1'b0, s_rx = 1'b0, s_rreq = 1'b0, s_accv = 1'b0;
    logic signed [23:0] s_acc = '0;
    logic               s_img_we, s_image_written, s_read_enable, s_mac_clr, s_mac_en;
    logic               s_layer_sel, s_act_we, s_NN_done;
    logic [9:0]         s_img_waddr, s_in_addr;
    logic [14:0]        s_w_addr;
    logic [5:0]         s_neuron_idx;
    logic [3:0]         s_digit_out;
    logic [52:0]        s_outs;
    assign s_outs = {s_img_we, s_img_waddr, s_image_written, s_read_enable, s_mac_clr, s_mac_en,
                     s_in_addr, s_layer_sel, s_w_addr, s_act_we, s_neuron_idx, s_NN_done, s_digit_out};

    nn_inference_sequencer #(.N_IN(S_IN), .N_HID(S_HID), .N_OUT(S_OUT), .MAC_LAT(MAC_LAT)) dut_s (
        .clk(clk), .reset(s_rst_n), .rx_byte_valid(s_rx), .read_request(s_rreq),
        .acc_in(s_acc), .acc_valid(s_accv),
        .img_we(s_img_we), .img_waddr(s_img_waddr), .image_written(s_image_written),
        .read_enable(s_read_enable), .mac_clr(s_mac_clr), .mac_en(s_mac_en),
        .in_addr(s_in_addr), .layer_sel(s_layer_sel), .w_addr(s_w_addr), .act_we(s_act_we),
        .neuron_idx(s_neuron_idx), .NN_done(s_NN_done), .digit_out(s_digit_out)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output-layer scores: max 40 at 3 ties with 4, lower index wins
    int big_sc[10] = '{-3, 12, 5, 40, 40, -100, 7, 39, 0, 2};
    int small_sc[3] = '{0, 0, 0};

    // Datapath models: acc_valid MAC_LAT cycles after the last mac_en cycle
    initial begin : dp_big
        int d;
        logic prev;
        d = 0;
        prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            accv = 1'b0;
            if (d > 0) begin
                d--;
                if (d == 0) begin
                    accv = 1'b1;
                    acc = b_layer_sel ? 24'(big_sc[b_neuron_idx]) : 24'(int'(b_neuron_idx) * 3 - 50);
                end
            end
            if (prev && !b_mac_en) d = MAC_LAT - 1;
            prev = b_mac_en;
        end
    end

    initial begin : dp_small
        int d;
        logic prev;
        d = 0;
        prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            s_accv = 1'b0;
            if (d > 0) begin
                d--;
                if (d == 0) begin
                    s_accv = 1'b1;
                    s_acc = s_layer_sel ? 24'(small_sc[s_neuron_idx]) : 24'(int'(s_neuron_idx) + 1);
                end
            end
            if (prev && !s_mac_en) d = MAC_LAT - 1;
            prev = s_mac_en;
        end
    end

    // Monitor for the full-size instance
    int m_we = 0, m_waddr_err = 0, m_clr = 0, m_mac = 0, m_act = 0, m_act_err = 0;
    int m_in_err = 0, m_w_err = 0, m_done_rise = 0, exp_in = 0, exp_w = 0, last_w = 0, l1_first_w = -1;
    logic prev_done = 1'b0;

    initial forever begin
        @(posedge clk); #1;
        if (b_img_we) begin
            if (int'(b_img_waddr) != m_we) m_waddr_err++;
            m_we++;
        end
        if (b_mac_clr) begin
            m_clr++;
            exp_in = 0;
        end
        if (b_mac_en) begin
            if (int'(b_in_addr) != exp_in) m_in_err++;
            if (int'(b_w_addr) != exp_w) m_w_err++;
            if (b_layer_sel && l1_first_w < 0) l1_first_w = int'(b_w_addr);
            exp_in++;
            exp_w++;
            last_w = int'(b_w_addr);
            m_mac++;
        end
        if (b_act_we) begin
            if (int'(b_neuron_idx) != m_act || b_layer_sel) m_act_err++;
            m_act++;
        end
        if (b_NN_done && !prev_done) m_done_rise++;
        prev_done = b_NN_done;
    end

    task automatic clear_mon();
        m_we = 0; m_waddr_err = 0; m_clr = 0; m_mac = 0; m_act = 0; m_act_err = 0;
        m_in_err = 0; m_w_err = 0; m_done_rise = 0; exp_in = 0; exp_w = 0; last_w = 0; l1_first_w = -1;
    endtask

    task automatic send_big(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rx_v = 1'b1;
            @(negedge clk); rx_v = 1'b0;
        end
    endtask

    task automatic send_small(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); s_rx = 1'b1;
            @(negedge clk); s_rx = 1'b0;
        end
    endtask

    task automatic wait_small(input int budget, output int n);
        n = 0;
        while (!s_NN_done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : main
        int n;
        logic re_mid;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'(b_outs), 64'd0);
        check("s_rst_outputs", 64'(s_outs), 64'd0);
        rst_n = 1'b1;
        s_rst_n = 1'b1;

        // image capture
        send_big(N_IN - 1);
        check("iw_before_last", b_image_written, 1'b0);
        send_big(1);
        check("iw_after_last", b_image_written, 1'b1);
        check("img_we_count", m_we, N_IN);
        check("img_addr_order", m_waddr_err, 0);
        check("load_no_mac", m_mac + m_clr, 0);
        check("load_no_re", b_read_enable, 1'b0);
        send_big(5);
        check("wait_req_rx_ignored", m_we, N_IN);

        // full inference, with stray rx strobes during MAC
        @(negedge clk);
        rreq = 1'b1;
        n = 0;
        re_mid = 1'b0;
        while (!b_NN_done && n < 40000) begin
            @(negedge clk);
            n++;
            rx_v = (n % 997 == 3);
            if (n == 100) re_mid = b_read_enable;
        end
        rx_v = 1'b0;
        check("done_reached", b_NN_done, 1'b1);
        check("latency_window", (n - 1 >= LAT_BIG - 1 && n - 1 <= LAT_BIG + 1), 1'b1);
        check("read_enable_busy", re_mid, 1'b1);
        check("read_enable_done", b_read_enable, 1'b0);
        check("mac_clr_count", m_clr, N_HID + N_OUT);
        check("mac_en_count", m_mac, N_HID*N_IN + N_OUT*N_HID);
        check("final_w_addr", last_w, N_HID*N_IN + N_OUT*N_HID - 1);
        check("l1_first_w_addr", l1_first_w, N_IN*N_HID);
        check("w_addr_seq", m_w_err, 0);
        check("in_addr_seq", m_in_err, 0);
        check("act_we_count", m_act, N_HID);
        check("act_we_idx", m_act_err, 0);
        check("done_rises", m_done_rise, 1);
        check("digit_tie_low", b_digit_out, 4'd3);
        check("mac_rx_ignored", m_we, N_IN);

        rreq = 1'b0;
        repeat (20) @(negedge clk);
`ifndef NN_RELOAD_EN
        check("done_terminal", b_NN_done, 1'b1);
        check("done_digit_hold", b_digit_out, 4'd3);
`endif

        // abort mid-MAC at neuron 5
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_big(N_IN);
        @(negedge clk);
        rreq = 1'b1;
        n = 0;
        while (!(b_neuron_idx == 6'd5 && b_mac_en && b_in_addr == 10'd100) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("reached_n5", (b_neuron_idx == 6'd5 && b_mac_en), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_all_zero", 64'(b_outs), 64'd0);
        rreq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        send_big(N_IN);
        check("reload_img_we", m_we, N_IN);
        check("reload_addr_order", m_waddr_err, 0);
        check("reload_iw", b_image_written, 1'b1);
        check("reload_no_mac", m_mac, 0);

        // reduced config argmax
        send_small(S_IN);
        check("s_iw", s_image_written, 1'b1);
        small_sc = '{5, -2, 9};
        @(negedge clk);
        s_rreq = 1'b1;
        wait_small(1000, n);
        check("s_done1", s_NN_done, 1'b1);
        check("s_latency1", (n - 1 >= LAT_SMALL - 1 && n - 1 <= LAT_SMALL + 1), 1'b1);
        check("s_digit_5_m2_9", s_digit_out, 4'd2);
        s_rreq = 1'b0;
        repeat (5) @(negedge clk);
`ifdef NN_RELOAD_EN
        check("s_reload_done_clr", s_NN_done, 1'b0);
        check("s_reload_iw_clr", s_image_written, 1'b0);
        check("s_reload_digit_hold", s_digit_out, 4'd2);
        send_small(S_IN);
        check("s_reload_iw", s_image_written, 1'b1);
`else
        check("s_done_terminal", s_NN_done, 1'b1);
        check("s_iw_hold", s_image_written, 1'b1);
        s_rst_n = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1;
        send_small(S_IN);
`endif
        small_sc = '{7, 7, 1};
        @(negedge clk);
        s_rreq = 1'b1;
        wait_small(1000, n);
        check("s_done2", s_NN_done, 1'b1);
        check("s_digit_7_7_1", s_digit_out, 4'd0);
        s_rreq = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
